// File: rtl/xup_debounce6_if.sv
// Purpose : Bundle of the six raw input lines and the conditioned outputs of
//           xup_debounce6.
// Signals : din[5:0]  raw asynchronous lines (din[0] -> a ... din[5] -> f)
//           a..f      debounced, registered levels
//           rise[5:0] one-cycle pulse when a level goes 0->1
//           fall[5:0] one-cycle pulse when a level goes 1->0
// Modports: master = source of din / consumer of levels, slave = debouncer.
interface xup_debounce6_if;
  logic [5:0] din;
  logic       a;
  logic       b;
  logic       c;
  logic       d;
  logic       e;
  logic       f;
  logic [5:0] rise;
  logic [5:0] fall;

  modport master (
    output din,
    input  a, b, c, d, e, f, rise, fall
  );

  modport slave (
    input  din,
    output a, b, c, d, e, f, rise, fall
  );
endinterface

// File: rtl/xup_debounce6.sv
// Purpose : Six-channel synchroniser + debouncer feeding the XUP 6-input gate
//           primitives. Each channel follows its synchronised input only after
//           DEBOUNCE_CYCLES consecutive cycles of disagreement with the output.
// Ports   : clk   - system clock, rising edge
//           reset - asynchronous, active-high, clears all state
//           bus   - xup_debounce6_if.slave (din in; a..f, rise, fall out)
// Params  : DEBOUNCE_CYCLES - stability count, legal range 2..2^24
// Macro   : XUP_DEBOUNCE6_EDGE_EN - when defined, rise/fall pulses are
//           generated; otherwise they are tied to zero.
module xup_debounce6 #(
  parameter int unsigned DEBOUNCE_CYCLES = 100000
) (
  input logic            clk,
  input logic            reset,
  xup_debounce6_if.slave bus
);
  localparam int unsigned NCH   = 6;
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NCH-1:0]            s1_q;
  logic [NCH-1:0]            s2_q;
  logic [NCH-1:0]            q_q;
  logic [NCH-1:0]            q_d;
  logic [NCH-1:0][CNT_W-1:0] cnt_q;
  logic [NCH-1:0][CNT_W-1:0] cnt_d;
  logic [NCH-1:0]            fire;

  // Per-channel stability counter; the terminal-count compare always fires
  // before the counter could wrap.
  always_comb begin
    q_d   = q_q;
    cnt_d = '0;
    fire  = '0;
    for (int i = 0; i < NCH; i++) begin
      if (s2_q[i] != q_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          q_d[i]  = s2_q[i];
          fire[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Synchroniser, stable level and counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q  <= '0;
      s2_q  <= '0;
      q_q   <= '0;
      cnt_q <= '0;
    end else begin
      s1_q  <= bus.din;
      s2_q  <= s1_q;
      q_q   <= q_d;
      cnt_q <= cnt_d;
    end
  end

`ifdef XUP_DEBOUNCE6_EDGE_EN
  logic [NCH-1:0] rise_q;
  logic [NCH-1:0] rise_d;
  logic [NCH-1:0] fall_q;
  logic [NCH-1:0] fall_d;

  // Pulse registered alongside q so it marks the first cycle of the new level.
  always_comb begin
    rise_d = fire & s2_q;
    fall_d = fire & ~s2_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign bus.rise = rise_q;
  assign bus.fall = fall_q;
`else
  assign bus.rise = '0;
  assign bus.fall = '0;
`endif

  assign bus.a = q_q[0];
  assign bus.b = q_q[1];
  assign bus.c = q_q[2];
  assign bus.d = q_q[3];
  assign bus.e = q_q[4];
  assign bus.f = q_q[5];
endmodule

// File: tb/tb_xup_debounce6.sv
// Purpose : Scoreboard bench for xup_debounce6 with DEBOUNCE_CYCLES = 4.
//           Each stimulus step pushes the hand-derived output expected after
//           its sampling edge; a monitor pops and compares after every edge.
module tb_xup_debounce6;
  localparam int unsigned NCH = 6;

`ifdef XUP_DEBOUNCE6_EDGE_EN
  localparam logic [5:0] EMASK = 6'h3F;
`else
  localparam logic [5:0] EMASK = 6'h00;
`endif

  logic clk;
  logic reset;

  xup_debounce6_if bus ();

  xup_debounce6 #(.DEBOUNCE_CYCLES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0] lvl;
    logic [5:0] rise;
    logic [5:0] fall;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec;
  int   n_err;

  // Downstream NOR6 built from the debounced outputs.
  logic [5:0] act_lvl;
  logic       nor6;
  assign act_lvl = {bus.f, bus.e, bus.d, bus.c, bus.b, bus.a};
  assign nor6    = ~|act_lvl;

  task automatic check(input string name, input exp_t e);
    logic exp_nor;
    exp_nor = ~|e.lvl;
    n_vec++;
    if (act_lvl !== e.lvl || bus.rise !== e.rise || bus.fall !== e.fall
        || nor6 !== exp_nor) begin
      n_err++;
      $display("FAIL %s t=%0t: lvl=%h rise=%h fall=%h nor6=%b, expected lvl=%h rise=%h fall=%h nor6=%b",
               name, $time, act_lvl, bus.rise, bus.fall, nor6,
               e.lvl, e.rise, e.fall, exp_nor);
    end
  endtask

  // One clock of stimulus; din/reset change at negedge, sampled at next posedge.
  task automatic step(input logic rst_v, input logic [5:0] d,
                      input logic [5:0] l, input logic [5:0] r,
                      input logic [5:0] f, input int unsigned n);
    exp_t e;
    for (int unsigned k = 0; k < n; k++) begin
      @(negedge clk);
      reset   = rst_v;
      bus.din = d;
      e.lvl   = l;
      e.rise  = r & EMASK;
      e.fall  = f & EMASK;
      exp_q.push_back(e);
      @(posedge clk);
    end
  endtask

  // Monitor: outputs are presented every cycle, compared 1 time unit after edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("cycle", e);
      end
    end
  end

  initial begin
    exp_t z;
    z       = '0;
    n_vec   = 0;
    n_err   = 0;
    reset   = 1'b1;
    bus.din = 6'h00;
    repeat (2) @(negedge clk);
    check("in_reset", z);

    // Idle after reset: everything stays low.
    step(1'b0, 6'h00, 6'h00, 6'h00, 6'h00, 20);

    // din[0] rises: a follows 5 edges after first sampling edge.
    step(1'b0, 6'h01, 6'h00, 6'h00, 6'h00, 5);
    step(1'b0, 6'h01, 6'h01, 6'h01, 6'h00, 1);
    step(1'b0, 6'h01, 6'h01, 6'h00, 6'h00, 4);
    step(1'b0, 6'h00, 6'h01, 6'h00, 6'h00, 5);
    step(1'b0, 6'h00, 6'h00, 6'h00, 6'h01, 1);
    step(1'b0, 6'h00, 6'h00, 6'h00, 6'h00, 4);

    // din[2] glitch of 3 sampled edges is filtered.
    step(1'b0, 6'h04, 6'h00, 6'h00, 6'h00, 3);
    step(1'b0, 6'h00, 6'h00, 6'h00, 6'h00, 8);

    // din[2] pulse of 4 sampled edges passes, then falls 4 edges after s2.
    step(1'b0, 6'h04, 6'h00, 6'h00, 6'h00, 4);
    step(1'b0, 6'h00, 6'h00, 6'h00, 6'h00, 1);
    step(1'b0, 6'h00, 6'h04, 6'h04, 6'h00, 1);
    step(1'b0, 6'h00, 6'h04, 6'h00, 6'h00, 3);
    step(1'b0, 6'h00, 6'h00, 6'h00, 6'h04, 1);
    step(1'b0, 6'h00, 6'h00, 6'h00, 6'h00, 3);

    // All six channels together; NOR6 drops on the same edge.
    step(1'b0, 6'h3F, 6'h00, 6'h00, 6'h00, 5);
    step(1'b0, 6'h3F, 6'h3F, 6'h3F, 6'h00, 1);
    step(1'b0, 6'h3F, 6'h3F, 6'h00, 6'h00, 3);
    step(1'b0, 6'h00, 6'h3F, 6'h00, 6'h00, 5);
    step(1'b0, 6'h00, 6'h00, 6'h00, 6'h3F, 1);
    step(1'b0, 6'h00, 6'h00, 6'h00, 6'h00, 3);

    // din[5] high, partial count interrupted by an asynchronous reset.
    step(1'b0, 6'h20, 6'h00, 6'h00, 6'h00, 3);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_mid_count", z);
    step(1'b1, 6'h20, 6'h00, 6'h00, 6'h00, 2);
    step(1'b0, 6'h20, 6'h00, 6'h00, 6'h00, 5);
    step(1'b0, 6'h20, 6'h20, 6'h20, 6'h00, 1);
    step(1'b0, 6'h20, 6'h20, 6'h00, 6'h00, 2);

    // Reset while f is high clears it at once.
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_level_high", z);
    step(1'b1, 6'h00, 6'h00, 6'h00, 6'h00, 2);
    step(1'b0, 6'h00, 6'h00, 6'h00, 6'h00, 6);

    #3;
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
